// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the default boot ROM address window.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR    = 32'hBFC0_0000;
    localparam logic [31:0] DEF_LAST_INSTR_ADDR = 32'hBFC0_0FFF;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, instr} pairs; flush empties it in one cycle and
// the head reads as zero whenever the buffer is empty.
module fetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   wr_pc,
    input  logic [DATA_WIDTH-1:0]   wr_instr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   head_pc,
    output logic [DATA_WIDTH-1:0]   head_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;

    // Occupancy update; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push, pop})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and count registers; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Entry storage; when full, push+pop overwrites the slot being retired.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            pc_mem_r[wr_ptr_r]    <= wr_pc;
            instr_mem_r[wr_ptr_r] <= wr_instr;
        end
    end

    assign count = count_r;
    assign valid = (count_r != {CW{1'b0}});

    // Head view, forced to zero while empty.
    always_comb begin
        if (valid) begin
            head_pc    = pc_mem_r[rd_ptr_r];
            head_instr = instr_mem_r[rd_ptr_r];
        end else begin
            head_pc    = {DATA_WIDTH{1'b0}};
            head_instr = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential prefetch from a combinational ROM into
// a small buffer, with redirect handling and an out-of-range fault state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR    = DEF_RESET_VECTOR,
    parameter logic [DATA_WIDTH-1:0] LAST_INSTR_ADDR = DEF_LAST_INSTR_ADDR,
    parameter int                    FIFO_DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  fault_o
);

    localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] LAST_WORD  = LAST_INSTR_ADDR & ALIGN_MASK;

    function automatic logic in_range(input logic [DATA_WIDTH-1:0] addr);
        return (addr >= RESET_VECTOR) && (addr <= LAST_INSTR_ADDR);
    endfunction

    fetch_state_e          state_r;
    fetch_state_e          next_state_s;
    logic [DATA_WIDTH-1:0] fetch_pc_r;
    logic [DATA_WIDTH-1:0] next_pc_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic                  fault_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic [CW-1:0]         count_s;
    logic                  valid_s;
    logic [DATA_WIDTH-1:0] head_pc_s;
    logic [DATA_WIDTH-1:0] head_instr_s;

    assign target_s   = redirect_addr_i & ALIGN_MASK;
    assign mem_addr_o = fetch_pc_r & ALIGN_MASK;
    assign pop_s      = valid_s && instr_ready_i;

    // Push only while running and not redirecting; a pop frees a slot this cycle.
    always_comb begin
        if ((state_r == RUN) && !redirect_i && ((count_s < DEPTH_C) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next state and fetch address; redirect takes priority over sequential fetch.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = fetch_pc_r;
        flush_s      = 1'b0;
        case (state_r)
            BOOT: begin
                next_state_s = RUN;
            end
            RUN, FAULT: begin
                if (redirect_i) begin
                    flush_s   = 1'b1;
                    next_pc_s = target_s;
                    if (in_range(target_s)) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = FAULT;
                    end
                end else if (push_s) begin
                    next_pc_s = fetch_pc_r + PC_STEP;
                    // The last ROM word has been fetched: stop before running off the end.
                    if (fetch_pc_r == LAST_WORD) begin
                        next_state_s = FAULT;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = state_r;
                    next_pc_s    = fetch_pc_r;
                end
            end
            default: begin
                next_state_s = BOOT;
            end
        endcase
    end

    // State, fetch address and registered fault flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= BOOT;
            fetch_pc_r <= RESET_VECTOR;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            fetch_pc_r <= next_pc_s;
            fault_r    <= (next_state_s == FAULT);
        end
    end

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (flush_s),
        .push       (push_s),
        .pop        (pop_s),
        .wr_pc      (fetch_pc_r),
        .wr_instr   (mem_instr_i),
        .count      (count_s),
        .valid      (valid_s),
        .head_pc    (head_pc_s),
        .head_instr (head_instr_s)
    );

    assign instr_valid_o = valid_s;
    assign instr_o       = head_instr_s;
    assign pc_o          = head_pc_s;
    assign fault_o       = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed per-cycle vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RV    = 32'hBFC0_0000;
    localparam logic [31:0] LAST  = 32'hBFC0_0FFF;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        rst_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fault_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_unit #(
        .DATA_WIDTH      (32),
        .RESET_VECTOR    (RV),
        .LAST_INSTR_ADDR (LAST),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .mem_addr_o      (mem_addr_o),
        .mem_instr_i     (mem_instr_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .fault_o         (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: one byte per address, word returned big-endian.
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {rom_byte(a), rom_byte(a + 32'd1), rom_byte(a + 32'd2), rom_byte(a + 32'd3)};
    endfunction

    assign mem_instr_i = rom_word(mem_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: mode 0 = booting, 1 = fetching, 2 = faulted.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = RV;
    int          m_mode = 0;

    task automatic model_update(input logic r, input logic rd, input logic [31:0] ra, input logic rdy);
        bit   popped;
        ent_t e;
        if (r) begin
            mq.delete();
            m_pc   = RV;
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            popped = (mq.size() != 0) && rdy;
            if (rd) begin
                mq.delete();
                m_pc   = ra & ~32'h3;
                m_mode = (m_pc >= RV && m_pc <= LAST) ? 1 : 2;
            end else begin
                if (popped) void'(mq.pop_front());
                if (m_mode == 1 && mq.size() < DEPTH) begin
                    e.pc    = m_pc;
                    e.instr = rom_word(m_pc);
                    mq.push_back(e);
                    if (m_pc == (LAST & ~32'h3)) m_mode = 2;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic model_compare(input string tag);
        logic        v;
        logic [31:0] p;
        logic [31:0] ins;
        v   = (mq.size() != 0);
        p   = v ? mq[0].pc : 32'h0;
        ins = v ? mq[0].instr : 32'h0;
        check({tag, " valid"}, {31'h0, instr_valid_o}, {31'h0, v});
        check({tag, " pc"}, pc_o, p);
        check({tag, " instr"}, instr_o, ins);
        check({tag, " fault"}, {31'h0, fault_o}, {31'h0, (m_mode == 2)});
        check({tag, " addr"}, mem_addr_o, m_pc & ~32'h3);
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] ra, input logic rdy);
        rst_i           = r;
        redirect_i      = rd;
        redirect_addr_i = ra;
        instr_ready_i   = rdy;
        @(posedge clk);
        model_update(r, rd, ra, rdy);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] raddr;
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic        fault;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] ra, input logic rdy,
                                input logic v, input logic [31:0] p, input logic f, input logic [31:0] a);
        vec_t t;
        t.rst = r; t.redir = rd; t.raddr = ra; t.ready = rdy;
        t.valid = v; t.pc = p; t.fault = f; t.addr = a;
        return t;
    endfunction

    initial begin
        logic        r;
        logic        rd;
        logic        rdy;
        logic [31:0] ra;
        logic [31:0] exp_instr;

        rst_i = 1'b1; redirect_i = 1'b0; redirect_addr_i = 32'h0; instr_ready_i = 1'b0;

        // Reset release and streaming
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00004);
        tbl[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00004,  1'b0, 32'hBFC00008);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00008,  1'b0, 32'hBFC0000C);
        // Back-pressure: buffer fills, fetch address holds
        tbl[5]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00004);
        tbl[8]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00008);
        tbl[9]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00008);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00008);
        // Redirect with pop, unaligned target
        tbl[11] = mk(1'b0, 1'b1, 32'hBFC00103,  1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00100);
        tbl[12] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00100,  1'b0, 32'hBFC00104);
        // Out-of-range redirect, then recovery
        tbl[13] = mk(1'b0, 1'b1, 32'h00000000,  1'b1, 1'b0, 32'h0,         1'b1, 32'h00000000);
        tbl[14] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h00000000);
        tbl[15] = mk(1'b0, 1'b1, 32'hBFC00010,  1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00010);
        tbl[16] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00010,  1'b0, 32'hBFC00014);
        // End of ROM
        tbl[17] = mk(1'b0, 1'b1, 32'hBFC00FF8,  1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00FF8);
        tbl[18] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00FF8,  1'b0, 32'hBFC00FFC);
        tbl[19] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00FFC,  1'b1, 32'hBFC01000);
        tbl[20] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC01000);
        tbl[21] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC01000);
        // Reset with a full buffer, overriding a redirect; BOOT ignores redirect
        tbl[22] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[23] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[24] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00004);
        tbl[25] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00008);
        tbl[26] = mk(1'b1, 1'b1, 32'hBFC00200,  1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[27] = mk(1'b0, 1'b1, 32'h00000000,  1'b1, 1'b0, 32'h0,         1'b0, 32'hBFC00000);
        tbl[28] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hBFC00000,  1'b0, 32'hBFC00004);

        @(negedge clk);
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].rst, tbl[i].redir, tbl[i].raddr, tbl[i].ready);
            exp_instr = tbl[i].valid ? rom_word(tbl[i].pc) : 32'h0;
            check($sformatf("row%0d valid", i), {31'h0, instr_valid_o}, {31'h0, tbl[i].valid});
            check($sformatf("row%0d pc", i), pc_o, tbl[i].pc);
            check($sformatf("row%0d instr", i), instr_o, exp_instr);
            check($sformatf("row%0d fault", i), {31'h0, fault_o}, {31'h0, tbl[i].fault});
            check($sformatf("row%0d addr", i), mem_addr_o, tbl[i].addr);
            model_compare($sformatf("row%0d model", i));
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       ra = RV + 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 3));
                1:       ra = LAST - 32'($urandom_range(0, 31));
                2:       ra = $urandom();
                default: ra = RV - 32'($urandom_range(1, 16));
            endcase
            step(r, rd, ra, rdy);
            model_compare($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning address and instruction width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-003 SHALL have parameter LAST_INSTR_ADDR, default 32'hBFC00FFF, meaning the last valid byte address of the instruction ROM.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of prefetch buffer entries (power of 2, at least 2).
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock (rising edge).
REQ-006 SHALL have port rst_i, input, 1 bit, reset (synchronous, active-high).
REQ-007 SHALL have port mem_addr_o, output, DATA_WIDTH bits, the word-aligned fetch address to the ROM, which answers combinationally in the same cycle.
REQ-008 SHALL have port mem_instr_i, input, DATA_WIDTH bits, the big-endian instruction word returned by the ROM.
REQ-009 SHALL have port redirect_i, input, 1 bit, a branch/jump/exception redirect request.
REQ-010 SHALL have port redirect_addr_i, input, DATA_WIDTH bits, the redirect target.
REQ-011 SHALL have port instr_valid_o, output, 1 bit, meaning the head entry is valid.
REQ-012 SHALL have port instr_ready_i, input, 1 bit, meaning decode accepts the head entry.
REQ-013 SHALL have port instr_o, output, DATA_WIDTH bits, the head instruction.
REQ-014 SHALL have port pc_o, output, DATA_WIDTH bits, the head instruction's address.
REQ-015 SHALL have port fault_o, output, 1 bit, meaning the fetch address is outside [RESET_VECTOR, LAST_INSTR_ADDR].

Function
REQ-016 SHALL implement FSM states BOOT, RUN and FAULT; rst_i forces BOOT; BOOT goes to RUN unconditionally after one cycle.
REQ-017 SHALL drive mem_addr_o = fetch_pc with bits [1:0] forced to 0 at all times.
REQ-018 SHALL define push as (state==RUN) and not redirect_i and (count<FIFO_DEPTH or pop); on push it SHALL write {fetch_pc, mem_instr_i} to the tail and set fetch_pc to fetch_pc+4.
REQ-019 SHALL define pop as instr_valid_o and instr_ready_i; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 SHALL make instr_valid_o = (count!=0), driven from registers, so a word pushed at edge N is visible after edge N.
REQ-021 SHALL drive instr_o and pc_o to 0 when count==0.
REQ-022 SHALL keep instr_o and pc_o stable while instr_valid_o=1 and instr_ready_i=0.
REQ-023 SHALL, on redirect_i=1 in any non-BOOT state: clear the FIFO (count=0 next cycle, even if pop was asserted), suppress push that cycle, and set fetch_pc to redirect_addr_i & ~3.
REQ-024 SHALL go to FAULT when a redirect target lies out of range, otherwise to RUN; in BOOT, redirect_i SHALL be ignored.
REQ-025 SHALL, when a push occurs at fetch_pc = LAST_INSTR_ADDR & ~3, go to FAULT next cycle; entries already buffered SHALL still drain normally.
REQ-026 SHALL make fault_o = (state==FAULT), registered; in FAULT there SHALL be no push and fetch_pc SHALL hold.
REQ-027 SHALL compute fetch_pc arithmetic modulo 2^DATA_WIDTH; wrap-around SHALL never be reached in range because of REQ-025.

Reset
REQ-028 SHALL, when rst_i=1 at a rising edge, set state=BOOT, fetch_pc=RESET_VECTOR, count=0, FIFO pointers=0 and fault_o=0, giving instr_valid_o=0 and instr_o=pc_o=0 next cycle.
REQ-029 SHALL let rst_i mid-operation override redirect_i, push and pop in the same cycle.
REQ-030 SHALL produce the first instr_valid_o=1, with pc_o=RESET_VECTOR, two cycles after rst_i deasserts.

Structure
REQ-031 SHALL place the FSM state enum (BOOT/RUN/FAULT) and the RESET_VECTOR/LAST_INSTR_ADDR constants in shared package fetch_pkg.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo (synchronous, FIFO_DEPTH entries of {pc, instr}, flush input).

Verification
REQ-033 SHALL cover reset release with instr_ready_i=1 and a ROM model -> pc_o sequence BFC00000, BFC00004, BFC00008 on consecutive cycles from cycle 2, with instr_o matching the ROM bytes big-endian.
REQ-034 SHALL cover instr_ready_i=0 for 5 cycles -> count saturates at 2, mem_addr_o holds BFC00008, and head pc_o=BFC00000 stays stable.
REQ-035 SHALL cover redirect_i=1 to BFC00103 with pop asserted -> valid drops next cycle, then pc_o=BFC00100, and the popped old entry is not repeated.
REQ-036 SHALL cover redirect to 00000000 -> fault_o=1 next cycle, no valid output; then redirect to BFC00010 -> fault_o=0 and pc_o=BFC00010.
REQ-037 SHALL cover redirect to BFC00FF8 -> BFC00FF8 and BFC00FFC are delivered, then fault_o=1 and no further valid output.
REQ-038 SHALL cover rst_i asserted with 2 entries buffered -> valid=0 next cycle, then restart at BFC00000.
